inst_fetcher: RTL and testbench

Front-end sequencer that owns the program counter and feeds the instruction queue one instruction per cycle. Looks up a direct-mapped, one-word-per-line instruction cache, requests misses from the memory controller, applies static branch prediction, and pushes {inst, pc, rollback_pc, predicted_jump} into the queue while the queue's full warning is low. Sits between the memory controller and the instruction queue; redirected by the ROB on mispredict.

---
 rtl/inst_fetcher_pkg.sv | 25 ++
 rtl/inst_fetcher_if.sv | 30 +++
 rtl/inst_fetcher_icache.sv | 47 ++++
 rtl/inst_fetcher.sv | 149 ++++++++++++++
 tb/tb_inst_fetcher.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared types, opcodes and constants for the instruction fetcher
package inst_fetcher_pkg;

  typedef logic [31:0] ins_t;
  typedef logic [31:0] addr_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int ICACHE_LINES = 256;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // DRAIN: a miss is still outstanding but its word belongs to a squashed path
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} fetch_state_t;

  typedef struct packed {
    addr_t next_pc;
    addr_t rollback_pc;
    logic  taken;
  } pred_t;

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - queue, memory-controller and ROB signals of the instruction fetcher
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic  full_from_iq;
  logic  ok_flag_to_iq;
  ins_t  inst_to_iq;
  addr_t pc_to_iq;
  addr_t rollback_pc_to_iq;
  logic  predicted_jump_to_iq;
  logic  req_to_mc;
  addr_t addr_to_mc;
  logic  done_from_mc;
  ins_t  inst_from_mc;
  logic  rollback_flag_from_rob;
  addr_t rollback_pc_from_rob;

  modport master (
    input  full_from_iq, done_from_mc, inst_from_mc, rollback_flag_from_rob, rollback_pc_from_rob,
    output ok_flag_to_iq, inst_to_iq, pc_to_iq, rollback_pc_to_iq, predicted_jump_to_iq,
    output req_to_mc, addr_to_mc
  );

  modport slave (
    output full_from_iq, done_from_mc, inst_from_mc, rollback_flag_from_rob, rollback_pc_from_rob,
    input  ok_flag_to_iq, inst_to_iq, pc_to_iq, rollback_pc_to_iq, predicted_jump_to_iq,
    input  req_to_mc, addr_to_mc
  );

endinterface

// File: rtl/inst_fetcher_icache.sv
// rtl/inst_fetcher_icache.sv - direct-mapped one-word-per-line instruction cache
module inst_fetcher_icache
  import inst_fetcher_pkg::*;
#(
  parameter int LINES = ICACHE_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_word,
  output logic        hit,
  output ins_t        data,
  input  logic        fill_en,
  input  logic [29:0] fill_word,
  input  ins_t        fill_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  ins_t             data_mem [LINES];
  logic [IW-1:0]    lookup_idx;
  logic [IW-1:0]    fill_idx;

  // Word addresses: the low IW bits pick the line, the rest is the tag
  assign lookup_idx = lookup_word[IW-1:0];
  assign fill_idx   = fill_word[IW-1:0];
  assign hit        = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_word[29:IW]);
  assign data       = data_mem[lookup_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_word[29:IW];
      data_mem[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - pc owner: icache lookup, miss requests, static prediction, queue push
module inst_fetcher #(
  parameter int          ICACHE_LINES = inst_fetcher_pkg::ICACHE_LINES,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  inst_fetcher_if.master  bus
);
  import inst_fetcher_pkg::*;

  fetch_state_t state, state_n;
  addr_t pc, pc_n, addr, addr_n, pcq, pcq_n, rbq, rbq_n;
  ins_t  inst_q, inst_n, cache_data, word;
  logic  req, req_n, ok, ok_n, pj, pj_n;
  logic  hit, fill_en, push;
  pred_t pred;

  // Backward branches predicted taken; rollback_pc is always the path not chosen
  function automatic pred_t predict(input ins_t inst, input addr_t at);
    addr_t j_imm, b_imm, seq;
    pred_t p;
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    seq   = at + 32'd4;
    p     = '{next_pc: seq, rollback_pc: seq, taken: FALSE};
    case (inst[6:0])
      OPC_JAL:    p = '{next_pc: at + j_imm, rollback_pc: seq, taken: TRUE};
      OPC_BRANCH: begin
        if (b_imm[31]) p = '{next_pc: at + b_imm, rollback_pc: seq, taken: TRUE};
        else           p = '{next_pc: seq, rollback_pc: at + b_imm, taken: FALSE};
      end
      OPC_JALR:   p = '{next_pc: seq, rollback_pc: seq, taken: FALSE};
      default:    ;
    endcase
    return p;
  endfunction

  inst_fetcher_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (pc[31:2]),
    .hit         (hit),
    .data        (cache_data),
    .fill_en     (fill_en),
    .fill_word   (addr[31:2]),
    .fill_data   (bus.inst_from_mc)
  );

  assign word = (state == ST_WAIT) ? bus.inst_from_mc : cache_data;
  assign pred = predict(word, pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req    <= FALSE;
      addr   <= '0;
      ok     <= FALSE;
      inst_q <= '0;
      pcq    <= '0;
      rbq    <= '0;
      pj     <= FALSE;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req    <= req_n;
      addr   <= addr_n;
      ok     <= ok_n;
      inst_q <= inst_n;
      pcq    <= pcq_n;
      rbq    <= rbq_n;
      pj     <= pj_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req;
    addr_n  = addr;
    ok_n    = FALSE;
    inst_n  = inst_q;
    pcq_n   = pcq;
    rbq_n   = rbq;
    pj_n    = pj;
    fill_en = FALSE;
    push    = FALSE;
    if (rdy) begin
      unique case (state)
        ST_IDLE: begin
          if (!hit) begin
            req_n   = TRUE;
            addr_n  = {pc[31:2], 2'b00};
            state_n = ST_WAIT;
          end else if (!bus.full_from_iq) begin
            push = TRUE;
          end
        end
        ST_WAIT: begin
          // Queue full warning already carries slack for this one word
          if (bus.done_from_mc) begin
            fill_en = TRUE;
            req_n   = FALSE;
            push    = TRUE;
            state_n = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (bus.done_from_mc) begin
            fill_en = TRUE;
            req_n   = FALSE;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (push) begin
        ok_n   = TRUE;
        inst_n = word;
        pcq_n  = pc;
        rbq_n  = pred.rollback_pc;
        pj_n   = pred.taken;
        pc_n   = pred.next_pc;
      end
      if (bus.rollback_flag_from_rob) begin
        pc_n = bus.rollback_pc_from_rob;
        ok_n = FALSE;
        if (state == ST_IDLE) begin
          req_n   = req;
          addr_n  = addr;
          state_n = ST_IDLE;
        end else if (!bus.done_from_mc) begin
          state_n = ST_DRAIN;
        end
      end
    end
  end

  assign bus.ok_flag_to_iq        = ok;
  assign bus.inst_to_iq           = inst_q;
  assign bus.pc_to_iq             = pcq;
  assign bus.rollback_pc_to_iq    = rbq;
  assign bus.predicted_jump_to_iq = pj;
  assign bus.req_to_mc            = req;
  assign bus.addr_to_mc           = addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed and random checks of inst_fetcher against a push-stream model
module tb_inst_fetcher;

  localparam int LINES = 256;

  typedef struct {
    int unsigned cyc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rb;
    logic        pj;
  } push_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  inst_fetcher_if bus();

  inst_fetcher #(.ICACHE_LINES(LINES), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          lat = 3;
  bit          mc_hold = 1'b0;
  int          mc_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  push_t       pushes[$];
  logic [31:0] m_tag [int];
  logic [31:0] m_data [int];
  logic [31:0] m_pc;
  int unsigned m_base;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : 32'h00000013;
  endfunction

  function automatic logic [31:0] enc_branch(input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.ok_flag_to_iq === 1'b1)
      pushes.push_back('{cyc, bus.inst_to_iq, bus.pc_to_iq, bus.rollback_pc_to_iq, bus.predicted_jump_to_iq});
  end

  // Memory controller: completes a request lat cycles after it is first seen
  always @(posedge clk) begin
    #2;
    bus.done_from_mc = 1'b0;
    if (bus.req_to_mc === 1'b1 && !mc_hold && rst === 1'b0) begin
      mc_cnt++;
      if (mc_cnt >= lat) begin
        mc_cnt            = 0;
        bus.done_from_mc  = 1'b1;
        bus.inst_from_mc  = rd(bus.addr_to_mc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_fill(input logic [31:0] a);
    m_tag[int'((a >> 2) % LINES)]  = a >> 2;
    m_data[int'((a >> 2) % LINES)] = rd(a);
  endtask

  // Next push expected at m_pc: word via model cache, prediction from plain arithmetic
  task automatic model_step(output logic [31:0] inst, output logic [31:0] nxt,
                            output logic [31:0] rb, output logic pj, output bit hit);
    int idx;
    int b_off;
    int j_off;
    idx = int'((m_pc >> 2) % LINES);
    hit = m_tag.exists(idx) && (m_tag[idx] == (m_pc >> 2));
    if (hit) inst = m_data[idx];
    else begin
      inst = rd(m_pc);
      model_fill(m_pc);
    end
    b_off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048 - int'(inst[31]) * 4096;
    j_off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096 - int'(inst[31]) * 1048576;
    pj  = 1'b0;
    nxt = m_pc + 32'd4;
    rb  = m_pc + 32'd4;
    if (inst[6:0] == 7'b1101111) begin
      pj  = 1'b1;
      nxt = m_pc + 32'(j_off);
    end else if (inst[6:0] == 7'b1100011) begin
      if (b_off < 0) begin
        pj  = 1'b1;
        nxt = m_pc + 32'(b_off);
      end else begin
        rb = m_pc + 32'(b_off);
      end
    end
  endtask

  task automatic run_pushes(input int n, input bit freeze, input bit timed_first);
    logic [31:0] e_inst, e_nxt, e_rb;
    logic        e_pj;
    bit          e_hit;
    int unsigned due;
    int          waited;
    push_t       p;
    for (int i = 0; i < n; i++) begin
      model_step(e_inst, e_nxt, e_rb, e_pj, e_hit);
      due    = m_base + (e_hit ? 1 : 1 + lat);
      waited = 0;
      while (pushes.size() == 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      assert (pushes.size() != 0) else begin
        errors++;
        $error("FAIL push_timeout observed none expected push of pc %h", m_pc);
      end
      if (pushes.size() == 0) break;
      p = pushes.pop_front();
      check("push_pc", p.pc, m_pc);
      check("push_inst", p.inst, e_inst);
      check("push_rollback_pc", p.rb, e_rb);
      check("push_predicted", 32'(p.pj), 32'(e_pj));
      if (i > 0 || timed_first) check("push_cycle", p.cyc, due);
      m_base = p.cyc;
      m_pc   = e_nxt;
    end
    if (freeze) rdy = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    pushes.delete();
    rdy = 1'b1;
    bus.rollback_flag_from_rob = 1'b1;
    bus.rollback_pc_from_rob   = target;
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b0;
    check("rollback_no_push", 32'(pushes.size()), 32'd0);
    m_base = cyc;
    m_pc   = target;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.full_from_iq           = 1'b0;
    bus.done_from_mc           = 1'b0;
    bus.inst_from_mc           = '0;
    bus.rollback_flag_from_rob = 1'b0;
    bus.rollback_pc_from_rob   = '0;
    mem[32'h10] = enc_branch(-8);
    mem[32'h20] = enc_jal(32'h100);
    mem[32'h40] = 32'h00500093;
    repeat (3) @(negedge clk);
    check("reset_ok", 32'(bus.ok_flag_to_iq), 32'd0);
    check("reset_req", 32'(bus.req_to_mc), 32'd0);
    check("reset_addr", bus.addr_to_mc, 32'h0);
    check("reset_pc_to_iq", bus.pc_to_iq, 32'h0);
    check("reset_rollback_pc", bus.rollback_pc_to_iq, 32'h0);

    // Cold start at 0 with an addi
    rst    = 1'b0;
    m_base = cyc;
    m_pc   = 32'h0;
    @(negedge clk);
    check("first_req", 32'(bus.req_to_mc), 32'd1);
    check("first_addr", bus.addr_to_mc, 32'h0);
    run_pushes(1, 1'b0, 1'b1);
    @(negedge clk);
    check("second_req", 32'(bus.req_to_mc), 32'd1);
    check("second_addr", bus.addr_to_mc, 32'h4);
    run_pushes(2, 1'b1, 1'b1);

    // Backward-branch loop: cold fills, then one push per cycle from hits
    redirect(32'h10);
    run_pushes(9, 1'b1, 1'b1);

    // JAL forward jump
    redirect(32'h20);
    run_pushes(3, 1'b1, 1'b1);

    // Queue full during hits
    redirect(32'h10);
    run_pushes(2, 1'b0, 1'b1);
    bus.full_from_iq = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_no_push", 32'(pushes.size()), 32'd0);
    end
    bus.full_from_iq = 1'b0;
    m_base = m_base + 4;
    run_pushes(3, 1'b1, 1'b1);

    // Rollback while a miss is outstanding
    lat = 3;
    redirect(32'h40);
    @(negedge clk);
    check("wait_req", 32'(bus.req_to_mc), 32'd1);
    check("wait_addr", bus.addr_to_mc, 32'h40);
    bus.rollback_flag_from_rob = 1'b1;
    bus.rollback_pc_from_rob   = 32'h200;
    @(negedge clk);
    bus.rollback_flag_from_rob = 1'b0;
    check("drain_req_held", 32'(bus.req_to_mc), 32'd1);
    repeat (3) @(negedge clk);
    check("drain_no_push", 32'(pushes.size()), 32'd0);
    check("after_drain_req", 32'(bus.req_to_mc), 32'd1);
    check("after_drain_addr", bus.addr_to_mc, 32'h200);
    model_fill(32'h40);
    m_pc   = 32'h200;
    m_base = cyc - 1;
    run_pushes(2, 1'b1, 1'b1);
    redirect(32'h40);
    run_pushes(1, 1'b1, 1'b1);

    // rdy low in the middle of a miss
    redirect(32'h300);
    @(negedge clk);
    mc_hold = 1'b1;
    rdy     = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 32'(bus.req_to_mc), 32'd1);
      check("stall_addr", bus.addr_to_mc, 32'h300);
      check("stall_no_push", 32'(pushes.size()), 32'd0);
    end
    rdy     = 1'b1;
    mc_hold = 1'b0;
    run_pushes(2, 1'b1, 1'b0);

    // Random program mix
    for (int a = 32'h1000; a < 32'h1100; a += 4) begin
      case ($urandom_range(0, 4))
        0: mem[a] = {$urandom_range(0, 4095), 20'h00093} & 32'hFFF0_00FF | 32'h0000_0013;
        1: mem[a] = enc_branch(4 * (int'($urandom_range(0, 31)) - 16));
        2: mem[a] = enc_jal(4 * (int'($urandom_range(0, 31)) - 8));
        3: mem[a] = {$urandom_range(0, 4095), 20'h000E7} & 32'hFFF0_0FFF | 32'h0000_0067;
        default: mem[a] = {$urandom} & 32'hFFFF_FF80 | 32'h0000_0033;
      endcase
    end
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 4);
      redirect(32'h1000 + 32'(4 * $urandom_range(0, 63)));
      run_pushes(40, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed no completion expected finish");
    $fatal(1);
  end

endmodule
